io_board_interface: RTL and testbench
=====================================

IO_BOARD_INTERFACE -- requirements
Module: io_board_interface

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, giving the consecutive stable cycles required before a debounced input changes; legal range 1..65535.
REQ-002 The block SHALL have port clock, input, 1, system clock; the block has one clock only.
REQ-003 The block SHALL have port reset, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port KEY, input, 4, raw push-buttons, active-low (0 = pressed), asynchronous to clock.
REQ-005 The block SHALL have port SW, input, 10, raw slide switches, active-high, asynchronous to clock.
REQ-006 The block SHALL have port io_input_bus, output, 14, core-side input bus: [13:10] = KEY pressed (1 = pressed), [9:0] = SW.
REQ-007 The block SHALL have port io_output_bus, input, 52, core-side output bus: [51:45] HEX5, [44:38] HEX4, [37:31] HEX3, [30:24] HEX2, [23:17] HEX1, [16:10] HEX0, [9:0] LED; segment bit 1 = lit.
REQ-008 The block SHALL have ports HEX0..HEX5, output, 7 each, seven-segment drivers, active-low (0 = segment lit), bit n = segment n.
REQ-009 The block SHALL have port LEDR, output, 10, LED drivers, active-high.

Function
REQ-010 Each of the 14 raw inputs SHALL pass through its own two-flop synchronizer before any other use.
REQ-011 KEY bits SHALL be inverted after synchronization, so that every internal and io_input_bus bit reads 1 = active.
REQ-012 Each bit SHALL have an independent debouncer holding a stable value and a 16-bit counter.
REQ-013 When a bit's synchronized value equals its stable value, its counter SHALL be 0.
REQ-014 When the synchronized value differs from the stable value, the counter SHALL increment by 1 per cycle.
REQ-015 When the counter reaches DEBOUNCE_CYCLES-1 while the values still differ, on that clock edge the stable value SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-016 A glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the stable value; returning to the stable value mid-count SHALL clear the counter.
REQ-017 The counter SHALL never wrap.
REQ-018 Raw edge to io_input_bus change latency SHALL be 2 cycles (synchronizer) + DEBOUNCE_CYCLES cycles.
REQ-019 Simultaneous changes on several bits SHALL be debounced independently, with no cross-bit interaction.
REQ-020 io_input_bus SHALL be driven directly from the stable-value registers, so it is glitch-free and changes only on clock edges.
REQ-021 HEXn SHALL be registered as the bitwise inverse of its io_output_bus field, with 1-cycle latency.
REQ-022 LEDR SHALL be registered copy of io_output_bus[9:0], with 1-cycle latency.
REQ-023 The output registers SHALL update every cycle; they have no enable and no hold.

Reset
REQ-024 When reset=1 on a clock edge, the synchronizer flops SHALL load the inactive raw level: KEY flops 1, SW flops 0.
REQ-025 Under the same reset, all stable values SHALL load 0 and all counters SHALL load 0, so that io_input_bus = 14'h0000.
REQ-026 Under the same reset, HEX0..HEX5 SHALL load 7'h7F (all segments off) and LEDR SHALL load 10'h000.
REQ-027 Reset asserted mid-count SHALL abort the debounce; counting restarts from 0 after reset deasserts.
REQ-028 Reset SHALL have priority over all other updates.

Configuration
REQ-029 The macro IO_DEBOUNCE_EN, when defined, SHALL compile in the debouncers (REQ-012..REQ-019).
REQ-030 When IO_DEBOUNCE_EN is undefined, the debouncers and counters SHALL be absent, DEBOUNCE_CYCLES SHALL be ignored, and io_input_bus SHALL equal the synchronized, KEY-inverted value with 2-cycle latency; reset value stays 0.

Verification (DEBOUNCE_CYCLES=4, IO_DEBOUNCE_EN defined unless noted)
REQ-031 Reset with KEY=4'hF, SW=0 -> io_input_bus=14'h0000, HEX0..5=7'h7F, LEDR=0 on the first post-reset cycle.
REQ-032 SW[3] 0->1, held -> io_input_bus[3]=1 exactly 6 cycles after the edge; no change earlier.
REQ-033 KEY[0] low for 3 cycles, then high -> io_input_bus[10] stays 0 throughout; the counter returns to 0.
REQ-034 KEY=4'b0101 and SW=10'h3FF applied in the same cycle -> io_input_bus=14'h2BFF after 6 cycles, all bits in the same cycle.
REQ-035 io_output_bus = {7'h3F, 35'h0, 10'h2AA} -> 1 cycle later HEX5=7'h40, HEX4..HEX0=7'h7F, LEDR=10'h2AA.
REQ-036 Reset pulsed 2 cycles into a SW[0] debounce -> io_input_bus[0]=0, with a full 6-cycle latency measured from reset release; IO_DEBOUNCE_EN undefined -> SW[0] edge appears in 2 cycles.

Source files
------------

// File: rtl/io_board_interface_if.sv
// Core-side buses of the board I/O block: the core drives io_output_bus and reads io_input_bus.
interface io_board_interface_if;
    logic [13:0] io_input_bus;
    logic [51:0] io_output_bus;

    modport master (
        input  io_input_bus,
        output io_output_bus
    );

    modport slave (
        output io_input_bus,
        input  io_output_bus
    );
endinterface

// File: rtl/io_board_interface.sv
// Board I/O: synchronized (optionally debounced) KEY/SW inputs, registered HEX/LED outputs.
// Define IO_DEBOUNCE_EN to compile in the per-bit debouncers; otherwise DEBOUNCE_CYCLES is ignored.
module io_board_interface #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3:0]            KEY,
    input  logic [9:0]            SW,
    io_board_interface_if.slave   core,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic [6:0]            HEX4,
    output logic [6:0]            HEX5,
    output logic [9:0]            LEDR
);
    localparam int unsigned NBITS = 14;
    localparam logic [NBITS-1:0] RAW_IDLE = {4'hF, 10'h000};

    if (DEBOUNCE_CYCLES == 16'd0) begin : g_illegal_debounce
        $error("DEBOUNCE_CYCLES must be in 1..65535");
    end

    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [NBITS-1:0] active;

    assign raw = {KEY, SW};

    // Synchronizers reset to the idle raw level so no false edge follows reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign active = {~sync2[13:10], sync2[9:0]};

`ifdef IO_DEBOUNCE_EN
    logic [NBITS-1:0] stable;
    logic [15:0]      count [NBITS];

    // Counter only runs while a bit disagrees with its stable value; it tops out at DEBOUNCE_CYCLES-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable <= '0;
            for (int unsigned i = 0; i < NBITS; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NBITS; i++) begin
                if (active[i] == stable[i]) begin
                    count[i] <= '0;
                end else if (count[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    stable[i] <= active[i];
                    count[i]  <= '0;
                end else begin
                    count[i] <= count[i] + 16'd1;
                end
            end
        end
    end

    assign core.io_input_bus = stable;
`else
    assign core.io_input_bus = active;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            HEX0 <= '1;
            HEX1 <= '1;
            HEX2 <= '1;
            HEX3 <= '1;
            HEX4 <= '1;
            HEX5 <= '1;
            LEDR <= '0;
        end else begin
            HEX5 <= ~core.io_output_bus[51:45];
            HEX4 <= ~core.io_output_bus[44:38];
            HEX3 <= ~core.io_output_bus[37:31];
            HEX2 <= ~core.io_output_bus[30:24];
            HEX1 <= ~core.io_output_bus[23:17];
            HEX0 <= ~core.io_output_bus[16:10];
            LEDR <= core.io_output_bus[9:0];
        end
    end
endmodule

// File: tb/tb_io_board_interface.sv
// Directed bench for io_board_interface: expectations are queued with a due cycle and checked when due.
module tb_io_board_interface;
    localparam int unsigned DEB = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int unsigned LAT    = 2 + DEB;
    localparam bit          DEB_ON = 1'b1;
`else
    localparam int unsigned LAT    = 2;
    localparam bit          DEB_ON = 1'b0;
`endif

    localparam int unsigned S_BUS  = 0;
    localparam int unsigned S_LEDR = 1;
    localparam int unsigned S_HEX0 = 2;

    logic       clock;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    io_board_interface_if bus ();

    io_board_interface #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clock (clock),
        .reset (reset),
        .KEY   (KEY),
        .SW    (SW),
        .core  (bus.slave),
        .HEX0  (HEX0),
        .HEX1  (HEX1),
        .HEX2  (HEX2),
        .HEX3  (HEX3),
        .HEX4  (HEX4),
        .HEX5  (HEX5),
        .LEDR  (LEDR)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        string       tag;
        int unsigned sel;
        logic [13:0] exp;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic expect_at(input int unsigned dly, input string tag,
                             input int unsigned sel, input logic [13:0] exp);
        exp_t e;
        e.due = cyc + dly;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [13:0] observe(input int unsigned sel);
        case (sel)
            S_BUS:      return bus.io_input_bus;
            S_LEDR:     return {4'h0, LEDR};
            S_HEX0:     return {7'h00, HEX0};
            S_HEX0 + 1: return {7'h00, HEX1};
            S_HEX0 + 2: return {7'h00, HEX2};
            S_HEX0 + 3: return {7'h00, HEX3};
            S_HEX0 + 4: return {7'h00, HEX4};
            S_HEX0 + 5: return {7'h00, HEX5};
            default:    return 'x;
        endcase
    endfunction

    task automatic step(input int unsigned n);
        exp_t        e;
        exp_t        rest[$];
        logic [13:0] obs;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            rest.delete();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.due == cyc) begin
                    obs = observe(e.sel);
                    checks++;
                    assert (obs === e.exp) else begin
                        errors++;
                        $error("FAIL %s @cyc %0d: observed %h expected %h", e.tag, cyc, obs, e.exp);
                    end
                end else begin
                    rest.push_back(e);
                end
            end
            sb = rest;
        end
    endtask

    task automatic expect_hex_all(input int unsigned dly, input string tag, input logic [6:0] h5,
                                  input logic [6:0] h4, input logic [6:0] h3, input logic [6:0] h2,
                                  input logic [6:0] h1, input logic [6:0] h0);
        expect_at(dly, {tag, "_hex0"}, S_HEX0,     {7'h00, h0});
        expect_at(dly, {tag, "_hex1"}, S_HEX0 + 1, {7'h00, h1});
        expect_at(dly, {tag, "_hex2"}, S_HEX0 + 2, {7'h00, h2});
        expect_at(dly, {tag, "_hex3"}, S_HEX0 + 3, {7'h00, h3});
        expect_at(dly, {tag, "_hex4"}, S_HEX0 + 4, {7'h00, h4});
        expect_at(dly, {tag, "_hex5"}, S_HEX0 + 5, {7'h00, h5});
    endtask

    initial begin
        logic [13:0] exp;

        // Reset with outputs bus all ones: HEX must still read blank, LEDR zero.
        reset = 1'b1;
        KEY = 4'hF;
        SW = '0;
        bus.io_output_bus = '1;
        expect_at(3, "rst_bus", S_BUS, 14'h0000);
        expect_at(3, "rst_ledr", S_LEDR, 14'h0000);
        expect_hex_all(3, "rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        step(3);
        reset = 1'b0;
        bus.io_output_bus = '0;
        expect_at(1, "post_rst_bus", S_BUS, 14'h0000);
        expect_at(1, "post_rst_hex0", S_HEX0, 14'h007F);
        expect_at(1, "post_rst_ledr", S_LEDR, 14'h0000);
        step(2);

        // SW[3] rising edge: nothing until exactly LAT cycles later.
        SW[3] = 1'b1;
        for (int unsigned k = 1; k < LAT; k++) expect_at(k, "sw3_early", S_BUS, 14'h0000);
        expect_at(LAT, "sw3_on", S_BUS, 14'h0008);
        expect_at(LAT + 1, "sw3_hold", S_BUS, 14'h0008);
        step(LAT + 2);

        // Two back-to-back 3-cycle KEY[0] glitches; a counter that failed to clear would flip on the second.
        for (int unsigned k = 1; k <= 12; k++) begin
            exp = 14'h0008;
            if (!DEB_ON && ((k >= 2 && k <= 4) || (k >= 7 && k <= 9))) exp = exp | 14'h0400;
            expect_at(k, "key0_glitch", S_BUS, exp);
        end
        KEY = 4'b1110;
        step(3);
        KEY = 4'hF;
        step(2);
        KEY = 4'b1110;
        step(3);
        KEY = 4'hF;
        step(4);

        // Many bits change together and must all land on the same cycle.
        KEY = 4'b0101;
        SW = 10'h3FF;
        expect_at(LAT - 1, "multi_early", S_BUS, 14'h0008);
        expect_at(LAT, "multi_on", S_BUS, 14'h2BFF);
        expect_at(LAT + 1, "multi_hold", S_BUS, 14'h2BFF);
        step(LAT + 2);

        // Output path: two consecutive patterns, each visible one cycle after it is driven.
        bus.io_output_bus = {7'h3F, 35'h0, 10'h2AA};
        expect_hex_all(1, "out_a", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        expect_at(1, "out_a_ledr", S_LEDR, 14'h02AA);
        step(1);
        bus.io_output_bus = {7'h15, 7'h2A, 7'h33, 7'h4C, 7'h0F, 7'h70, 10'h155};
        expect_hex_all(1, "out_b", 7'h6A, 7'h55, 7'h4C, 7'h33, 7'h70, 7'h0F);
        expect_at(1, "out_b_ledr", S_LEDR, 14'h0155);
        step(2);

        // Return inputs to idle so the reset-abort test starts from zero.
        KEY = 4'hF;
        SW = '0;
        expect_at(LAT, "idle_bus", S_BUS, 14'h0000);
        step(LAT + 1);

        // Reset two cycles into an SW[0] debounce; full latency counts from reset release.
        SW[0] = 1'b1;
        step(2);
        reset = 1'b1;
        expect_at(1, "abort_rst_bus", S_BUS, 14'h0000);
        expect_at(1, "abort_rst_hex0", S_HEX0, 14'h007F);
        step(1);
        reset = 1'b0;
        for (int unsigned k = 1; k < LAT; k++) expect_at(k, "abort_early", S_BUS, 14'h0000);
        expect_at(LAT, "abort_on", S_BUS, 14'h0001);
        expect_at(1, "abort_hex0_back", S_HEX0, 14'h000F);
        step(LAT + 2);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
